// File: rtl/jstk2_pkg.sv
// Shared JSTK2 joystick definitions:
// frame geometry, responder states, command bytes.
package jstk2_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_BITS  = FRAME_BYTES * 8;

  localparam logic [7:0] CMD_LED_RGB   = 8'h84;
  localparam logic [7:0] CMD_LED_ONOFF = 8'hC0;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    LOAD,
    SHIFT,
    END
  } state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [9:0] x,
    input logic [9:0] y,
    input logic       trg,
    input logic       jstk
  );
    return {x[7:0], 6'b0, x[9:8],
            y[7:0], 6'b0, y[9:8],
            6'b0, trg, jstk};
  endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchroniser for one async SPI line
// with rise/fall detection on the synced level.
module spi_input_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain; keep last level for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 slave emulating a Pmod JSTK2:
// serves the 5-byte position frame and decodes LED commands.
module jstk2_spi_responder
  import jstk2_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] LED_CMD     = CMD_LED_RGB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  x_pos,
  input  logic [9:0]  y_pos,
  input  logic        btn_jstk,
  input  logic        btn_trg,
  input  logic        SS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  output logic [23:0] led_rgb,
  output logic        led_valid,
  output logic        frame_done,
  output logic        frame_abort
);

  localparam logic [5:0] FULL = 6'(FRAME_BITS);

  logic ss_lvl, ss_fall, ss_rise_unused;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .rst(rst), .din(SS),
    .lvl(ss_lvl), .rise(ss_rise_unused), .fall(ss_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .rst(rst), .din(SCLK),
    .lvl(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_input_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .rst(rst), .din(MOSI),
    .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   shreg;
  logic [5:0]              rise_cnt;
  logic [31:0]             rx;
  logic                    edge_ok;
  logic                    full;

  // SS high wins over any SCLK edge seen in the same cycle
  assign edge_ok = (state_q == SHIFT) && !ss_lvl;
  assign full    = (rise_cnt == FULL);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT_IDLE;
    else      state_q <= state_d;
  end

  // Next state and tristate-side outputs
  always_comb begin
    state_d = state_q;
    MISO_oe = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (ss_lvl)  state_d = IDLE;
      IDLE:      if (ss_fall) state_d = LOAD;
      LOAD: begin
        MISO_oe = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        MISO_oe = 1'b1;
        if (ss_lvl) state_d = END;
      end
      END:       state_d = IDLE;
      default:   state_d = WAIT_IDLE;
    endcase
    MISO = MISO_oe & shreg[FRAME_BITS-1];
  end

  // Snapshot at frame start, then shift out on falls and collect MOSI on rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      rise_cnt <= '0;
      rx       <= '0;
    end else if (state_q == IDLE && ss_fall) begin
      shreg    <= build_frame(x_pos, y_pos, btn_trg, btn_jstk);
      rise_cnt <= '0;
      rx       <= '0;
    end else if (edge_ok) begin
      if (sclk_rise && !full) begin
        rise_cnt <= rise_cnt + 6'd1;
        if (rise_cnt < 6'd32) rx <= {rx[30:0], mosi_lvl};
      end
      if (sclk_fall) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Frame completion pulses and LED command latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      led_valid   <= 1'b0;
      led_rgb     <= '0;
    end else begin
      frame_done  <= (state_q == END) && full;
      frame_abort <= (state_q == END) && !full;
      led_valid   <= 1'b0;
      if (state_q == END && full && rx[31:24] == LED_CMD) begin
        led_rgb   <= rx[23:0];
        led_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Randomised scoreboard bench for the JSTK2 responder:
// an SPI master drives frames, a monitor checks each frame end.
module tb_jstk2_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x_pos, y_pos;
  logic        btn_jstk, btn_trg;
  logic        SS, SCLK, MOSI;
  logic        MISO, MISO_oe;
  logic [23:0] led_rgb;
  logic        led_valid, frame_done, frame_abort;

  jstk2_spi_responder dut (
    .clk(clk), .rst(rst),
    .x_pos(x_pos), .y_pos(y_pos),
    .btn_jstk(btn_jstk), .btn_trg(btn_trg),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe),
    .led_rgb(led_rgb), .led_valid(led_valid),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] bits;
    int          nbits;
    logic        done;
    logic        abort;
    logic        lv;
    logic [23:0] led;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [23:0] led_model = '0;
  logic [47:0] cap = '0;
  int          cap_n = 0;

  function automatic void chk(input string nm,
                              input logic [47:0] act,
                              input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endfunction

  // Master-side view of MISO, sampled on each SCLK rise
  always @(negedge SS) begin
    cap   = '0;
    cap_n = 0;
  end

  always @(posedge SCLK) begin
    if (SS === 1'b0 && cap_n < 48) begin
      cap[47-cap_n] = MISO;
      cap_n++;
    end
  end

  // Scoreboard monitor: every frame end pops one expectation
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (frame_done || frame_abort) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_end", {46'b0, frame_done, frame_abort}, 48'h0);
        end else begin
          exp_t e;
          logic [47:0] mask;
          e    = exp_q.pop_front();
          mask = ~48'h0 << (48 - e.nbits);
          chk("frame_done",  48'(frame_done),  48'(e.done));
          chk("frame_abort", 48'(frame_abort), 48'(e.abort));
          chk("led_valid",   48'(led_valid),   48'(e.lv));
          chk("led_rgb",     48'(led_rgb),     48'(e.led));
          chk("miso_bits",   cap & mask,       e.bits & mask);
        end
      end else if (led_valid) begin
        chk("led_valid_alone", 48'(led_valid), 48'h0);
      end
    end
  end

  task automatic frame(input int n, input logic [39:0] mosi,
                       input int ph, input int lead,
                       input int xat, input logic [9:0] xnew,
                       input int rat);
    exp_t e;
    logic oe_seen;
    int   idx;
    e.bits  = {x_pos[7:0], 6'b0, x_pos[9:8],
               y_pos[7:0], 6'b0, y_pos[9:8],
               6'b0, btn_trg, btn_jstk, 8'h00};
    e.nbits = n;
    e.done  = (n >= 40);
    e.abort = (n < 40);
    e.lv    = e.done && (mosi[39:32] == 8'h84);
    if (e.lv) led_model = mosi[31:8];
    e.led   = led_model;
    if (rat < 0) exp_q.push_back(e);
    @(negedge clk);
    SS   = 1'b0;
    MOSI = mosi[39];
    repeat (lead) @(negedge clk);
    if (rat < 0) chk("miso_oe_on", 48'(MISO_oe), 48'h1);
    oe_seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == xat) x_pos = xnew;
      if (i == rat) begin
        rst = 1'b0;
        #1;
        chk("rst_miso",    48'(MISO),        48'h0);
        chk("rst_miso_oe", 48'(MISO_oe),     48'h0);
        chk("rst_led_rgb", 48'(led_rgb),     48'h0);
        chk("rst_pulses",  48'({frame_done, frame_abort, led_valid}), 48'h0);
        led_model = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
      end
      SCLK = 1'b1;
      repeat (ph) @(negedge clk);
      if (rat >= 0 && i > rat) oe_seen |= MISO_oe;
      SCLK = 1'b0;
      idx  = 38 - i;
      MOSI = (idx >= 0) ? mosi[idx] : 1'b0;
      repeat (ph) @(negedge clk);
    end
    SS = 1'b1;
    if (rat >= 0) begin
      chk("no_resp_after_rst", 48'(oe_seen), 48'h0);
      repeat (30) @(negedge clk);
    end else begin
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
      chk("frame_end_seen", 48'(exp_q.size()), 48'h0);
      exp_q.delete();
      chk("miso_oe_off", 48'(MISO_oe), 48'h0);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] m;
    int          n;
    rst      = 1'b0;
    SS       = 1'b1;
    SCLK     = 1'b0;
    MOSI     = 1'b0;
    x_pos    = 10'h2A5;
    y_pos    = 10'h013;
    btn_trg  = 1'b1;
    btn_jstk = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_miso",    48'(MISO),        48'h0);
    chk("reset_miso_oe", 48'(MISO_oe),     48'h0);
    chk("reset_led_rgb", 48'(led_rgb),     48'h0);
    chk("reset_pulses",  48'({led_valid, frame_done, frame_abort}), 48'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1 MHz reads: plain frame, then x change mid-frame
    frame(40, 40'h0, 50, 50, -1, 10'h0, -1);
    frame(40, 40'h0, 50, 50, 10, 10'h3FF, -1);
    // LED command frame, then aborted LED frame
    frame(40, 40'h84_10_20_30_00, 10, 10, -1, 10'h0, -1);
    frame(20, 40'h84_AA_BB_CC_00, 10, 10, -1, 10'h0, -1);
    // Overlong frame
    frame(45, 40'h12_34_56_78_9A, 10, 10, -1, 10'h0, -1);
    // Reset at bit 17 while selected, then a clean frame
    frame(40, 40'h84_01_02_03_00, 10, 10, -1, 10'h0, 17);
    frame(40, 40'h84_0A_0B_0C_00, 10, 10, -1, 10'h0, -1);

    // Minimum-timing randomised frames
    for (int f = 0; f < 100; f++) begin
      x_pos    = 10'($urandom_range(0, 1023));
      y_pos    = 10'($urandom_range(0, 1023));
      btn_trg  = 1'($urandom);
      btn_jstk = 1'($urandom);
      m        = {8'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) m[39:32] = 8'h84;
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 45) : 40;
      frame(n, m, 4, 4, $urandom_range(0, 39),
            10'($urandom_range(0, 1023)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jstk2_spi_responder.md
Name: jstk2_spi_responder

Overview:
SPI-mode-0 slave that emulates the Pmod JSTK2 joystick module, i.e. the responder side of the 5-byte joystick frame our SPI joystick master reads. Joystick position and buttons come from on-chip sources (switches, test pattern, bench), so the steering chain can run without a physical JSTK2. Also decodes the master's RGB-LED command (0x84) from MOSI. All SPI inputs are asynchronous to clk and are oversampled.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the SS/SCLK/MOSI synchronisers (>=2).
LED_CMD, 8'h84, first MOSI byte that marks a set-RGB-LED frame.

Ports:
clk  input  1  system clock (100 MHz).
rst  input  1  asynchronous reset, active-low.
x_pos  input  10  X position 0..1023, sampled at frame start.
y_pos  input  10  Y position 0..1023, sampled at frame start.
btn_jstk  input  1  joystick push-button.
btn_trg  input  1  trigger button.
SS  input  1  slave select, active-low, async.
SCLK  input  1  SPI clock, idle low, async.
MOSI  input  1  master data, async.
MISO  output  1  slave data.
MISO_oe  output  1  1 while SS is low and selected (board tristate control).
led_rgb  output  24  {R,G,B} from the last valid LED command.
led_valid  output  1  one-clk pulse when led_rgb updates.
frame_done  output  1  one-clk pulse: frame of >=40 SCLK rises completed.
frame_abort  output  1  one-clk pulse: SS rose after fewer than 40 rises.

Behaviour:
- Reset (rst=0, async): MISO=0, MISO_oe=0, led_rgb=0, led_valid=0, frame_done=0, frame_abort=0, FSM=WAIT_IDLE, counters 0.
- Synchronise SS/SCLK/MOSI through SYNC_STAGES flops; edges are detected on synchronised values. Input timing requirement: SCLK high and low phases >=4 clk; SS low-to-first-SCLK-rise >=4 clk.
- Response frame, MSB first, 40 bits: byte0=x_pos[7:0], byte1={6'b0,x_pos[9:8]}, byte2=y_pos[7:0], byte3={6'b0,y_pos[9:8]}, byte4={6'b0,btn_trg,btn_jstk}.
- FSM:
  WAIT_IDLE: entered after reset; waits for synced SS=1 -> IDLE. A frame already in progress at reset release is ignored.
  IDLE: MISO_oe=0, MISO=0. Synced SS falling -> LOAD.
  LOAD (1 clk): snapshot x_pos/y_pos/buttons into the 40-bit shift register, drive bit39 on MISO, set MISO_oe=1 -> SHIFT. MISO is valid at most 1 clk after synced SS falls.
  SHIFT: synced SCLK rise -> sample synced MOSI into the rx byte, increment rise count (saturates at 40). Synced SCLK fall -> shift; MISO shows the next bit within 1 clk; after bit0, MISO=0. Synced SS rising -> END.
  END (1 clk): rise count=40 -> frame_done=1; otherwise frame_abort=1. MISO_oe=0 -> IDLE.
- Input changes during a frame do not affect it; the snapshot is held until the next LOAD.
- MOSI decode: rx byte 0 is compared with LED_CMD; bytes 1..3 are latched as R,G,B. At END, if byte0==LED_CMD and count=40, led_rgb updates and led_valid pulses in the same cycle as frame_done. Aborted or non-LED frames leave led_rgb unchanged.
- More than 40 SCLK rises: extra bits are ignored, MISO stays 0, and the frame still ends with frame_done.
- SS rise and SCLK edge in the same synced cycle: SS wins; the edge is ignored.
- Reset mid-frame: all outputs return to reset values immediately; the FSM re-enters WAIT_IDLE.

Decomposition:
- Package jstk2_pkg: FRAME_BYTES=5, FRAME_BITS=40, state enum (WAIT_IDLE, IDLE, LOAD, SHIFT, END), JSTK2 command constants (8'h84 LED RGB, 8'hC0 LED off/on) shared with the master.
- One sub-module, spi_input_sync: parameterised synchroniser plus rise/fall edge detector, instantiated once per SS/SCLK/MOSI (MOSI uses level only).

Test Plan:
- Reset, SS held high, x=0x2A5, y=0x013, btn_trg=1, btn_jstk=0 -> 40-bit mode-0 read at 1 MHz returns bytes A5,02,13,00,02; frame_done pulses once; MISO_oe=0 after SS high.
- x_pos changes to 0x3FF mid-frame -> that frame still returns A5,02; the next frame returns FF,03.
- MOSI bytes 84,10,20,30,00 -> led_rgb=0x102030 with led_valid and frame_done in the same clk; MOSI 84 with an abort after 20 bits -> frame_abort pulses, led_rgb stays 0x102030.
- 45 SCLK pulses -> first 40 bits correct, last 5 bits MISO=0, frame_done=1, frame_abort=0.
- rst asserted low at bit 17 while SS is low -> outputs reset at once; after release with SS still low, no response; the next full frame is correct.
- SCLK phase of exactly 4 clk and SS-to-SCLK of 4 clk -> no bit errors over 100 randomized frames.
